// File: rtl/checked_fifo_arbiter.sv
// Round-robin arbiter merging NUM_REQ requesters onto one FIFO push port in bounded bursts.
// Optional parity filter on owner words is compiled in with `define ARB_PARITY_FILTER_EN.
module checked_fifo_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 17,
  parameter int MAX_BURST  = 4,
  parameter bit PARITY     = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid_in,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_in,
  output logic [NUM_REQ-1:0]                  req_grant_out,
  output logic                                push_valid_out,
  input  logic                                push_grant_in,
  output logic [DATA_WIDTH-1:0]               push_data_out,
  output logic [$clog2(NUM_REQ)-1:0]          owner_out,
  output logic [7:0]                          err_cnt_out
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]    beat_q, beat_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [OW-1:0] pick;
  logic          pick_vld;
  logic          own_vld;
  logic          word_bad;
  logic          own_xfer;
  logic          last_beat;

  // EVEN (PARITY=1) rejects words with XOR 1; ODD (PARITY=0) rejects XOR 0.
  function automatic logic parity_bad(input logic [DATA_WIDTH-1:0] w);
    return (^w) == PARITY;
  endfunction

  // First valid requester searching upward from rr_ptr+1 with wrap.
  always_comb begin
    int idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!pick_vld && req_valid_in[idx]) begin
        pick     = OW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign own_vld = req_valid_in[owner_q];

`ifdef ARB_PARITY_FILTER_EN
  assign word_bad = own_vld && parity_bad(req_data_in[owner_q]);
`else
  assign word_bad = 1'b0;
`endif

  // Bad words are drained unconditionally so a corrupt requester cannot stall on a full FIFO.
  assign own_xfer  = (state_q == BURST) && own_vld && (word_bad || push_grant_in);
  assign last_beat = ({1'b0, beat_q} + 5'd1) == 5'(MAX_BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= OW'(NUM_REQ - 1);
      beat_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      beat_q    <= beat_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    beat_d    = beat_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (own_xfer) begin
          beat_d = beat_q + 4'd1;
        end
        if (!own_vld || (own_xfer && last_beat)) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (own_xfer && word_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    req_grant_out  = '0;
    push_valid_out = 1'b0;
    push_data_out  = '0;
    if (state_q == BURST) begin
      req_grant_out[owner_q] = word_bad || push_grant_in;
      push_valid_out         = own_vld && !word_bad;
      push_data_out          = req_data_in[owner_q];
    end
  end

  assign owner_out   = owner_q;
  assign err_cnt_out = err_cnt_q;

endmodule

// File: doc/checked_fifo_arbiter.md
CHECKED_FIFO_ARBITER -- requirements
Module: checked_fifo_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, the number of requesters sharing one FIFO push port (legal range 2..8).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 17, the width of each data word.
REQ-003 The module SHALL have parameter MAX_BURST, default 4, the maximum number of beats per grant tenure (legal range 1..16).
REQ-004 The module SHALL have parameter PARITY, default 1'b1, where 1'b1 means EVEN parity and 1'b0 means ODD parity.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 The module SHALL have port req_valid_in, input, NUM_REQ bits: per-requester data valid.
REQ-008 The module SHALL have port req_data_in, input, NUM_REQ x DATA_WIDTH bits: per-requester data words.
REQ-009 The module SHALL have port req_grant_out, output, NUM_REQ bits: per-requester word accepted.
REQ-010 The module SHALL have port push_valid_out, output, 1 bit: valid toward the FIFO push side.
REQ-011 The module SHALL have port push_grant_in, input, 1 bit: FIFO has space.
REQ-012 The module SHALL have port push_data_out, output, DATA_WIDTH bits: word toward the FIFO.
REQ-013 The module SHALL have port owner_out, output, $clog2(NUM_REQ) bits: the current owner index.
REQ-014 The module SHALL have port err_cnt_out, output, 8 bits: count of parity-rejected words.

Function
REQ-015 A transfer SHALL occur on a port only in a cycle where its valid and its grant are both 1.
REQ-016 The FSM SHALL have exactly two states, IDLE and BURST.
REQ-017 In IDLE, push_valid_out SHALL be 0 and all req_grant_out bits SHALL be 0.
REQ-018 In IDLE, if any req_valid_in bit is 1, the arbiter SHALL pick the first set index searching from rr_ptr+1 upward with wrap modulo NUM_REQ, register it as owner, and move to BURST next cycle (one cycle arbitration latency).
REQ-019 In BURST, push_valid_out SHALL be combinationally req_valid_in[owner], push_data_out SHALL be req_data_in[owner], req_grant_out[owner] SHALL be push_grant_in, and all other grant bits SHALL be 0.
REQ-020 A 4-bit beat counter SHALL clear on entry to BURST and increment on each owner transfer.
REQ-021 BURST SHALL exit to IDLE after the transfer that makes the beat count equal to MAX_BURST, or in any cycle where req_valid_in[owner] is 0.
REQ-022 On either BURST exit, rr_ptr SHALL be set to owner.
REQ-023 If push_grant_in is 0 (FIFO full), BURST SHALL hold with no beat counted; there is no timeout.
REQ-024 In BURST, a requester dropping valid while push_grant_in is 0 SHALL still end the tenure.
REQ-025 Requests from non-owners SHALL be ignored until the owner's tenure ends.
REQ-026 A requester that keeps valid high SHALL be served again only after every other valid requester has had one tenure.
REQ-027 owner_out SHALL show the registered owner in both states.
REQ-028 push_data_out SHALL be all zeros in IDLE.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state=IDLE, owner=0, rr_ptr=NUM_REQ-1 (so requester 0 has first priority), beat=0, and err_cnt=0.
REQ-030 During reset, all outputs SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL abandon the tenure; no partial state survives.

Configuration
REQ-032 The macro ARB_PARITY_FILTER_EN SHALL compile in the parity filter.
REQ-033 With ARB_PARITY_FILTER_EN defined, an owner word is bad when XOR of all its bits is 1 (PARITY=1) or 0 (PARITY=0).
REQ-034 With ARB_PARITY_FILTER_EN defined, a bad word SHALL get req_grant_out[owner]=1 regardless of push_grant_in, SHALL get push_valid_out=0, SHALL count as a beat, and SHALL increment err_cnt_out, saturating at 255.
REQ-035 Without ARB_PARITY_FILTER_EN, all words SHALL be forwarded unchecked and err_cnt_out SHALL be tied to 0.

Verification
REQ-036 Out of reset, with req_valid_in=4'b1111 held and push_grant_in=1: IDLE cycle, then owner 0 sends 4 beats, then IDLE, then owner 1 sends 4 beats, continuing 2, 3, 0.
REQ-037 With only req 2 valid, asserted for 2 beats then dropped: owner_out=2, exactly 2 transfers, return to IDLE, and rr_ptr=2.
REQ-038 push_grant_in=0 for 5 cycles mid-burst: no grants, beat count frozen, and the burst completes the remaining beats after grant returns.
REQ-039 rst_n pulsed low mid-burst: outputs 0 immediately, and the next tenure goes to requester 0.
REQ-040 With ARB_PARITY_FILTER_EN and PARITY=1, owner sends 17'h00001 (bad) then 17'h00003 (good): first word gets grant=1 with push_valid_out=0 and err_cnt_out=1, second word is forwarded.
REQ-041 With ARB_PARITY_FILTER_EN, 300 bad words sent: err_cnt_out=255.
